project_pwm_capture: RTL and testbench

PROJECT_PWM_CAPTURE -- requirements
Module: project_pwm_capture

---
 rtl/project_pwm_capture.sv | 150 +++++++++++++++
 tb/tb_project_pwm_capture.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/project_pwm_capture.sv
// PWM period / high-time capture: 2-flop synchronizer, programmable glitch
// filter, edge strobes and an IDLE/HIGH/LOW measurement FSM.
module project_pwm_capture #(
   parameter int P_WIDTH = 16
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_en,
   input  logic               i_pwm,
   input  logic [3:0]         i_filter,
   input  logic               i_clear,
   output logic [P_WIDTH-1:0] o_period,
   output logic [P_WIDTH-1:0] o_high,
   output logic               o_valid,
   output logic               o_overflow,
   output logic               o_level
);

   typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_t;

   localparam logic [P_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [P_WIDTH-1:0] CNT_ONE = {{(P_WIDTH-1){1'b0}}, 1'b1};

   logic [1:0]         sync_q;
   logic               level_q, level_d;
   logic [3:0]         run_q, run_d;
   logic               rise_q, rise_d, fall_q, fall_d;
   state_t             state_q, state_d;
   logic [P_WIDTH-1:0] per_q, per_d, high_q, high_d;
   logic [P_WIDTH-1:0] period_q, period_d, hout_q, hout_d;
   logic               valid_q, valid_d, ovf_q, ovf_d, ovf_set;

   // Level changes once the synchronized input has disagreed for i_filter+1 cycles;
   // '>=' keeps a run from wrapping if i_filter is lowered mid-run.
   always_comb begin
      level_d = level_q;
      run_d   = 4'd0;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (sync_q[1] != level_q) begin
         if (run_q >= i_filter) begin
            level_d = sync_q[1];
            rise_d  = sync_q[1];
            fall_d  = ~sync_q[1];
         end else begin
            run_d = run_q + 4'd1;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      per_d    = per_q;
      high_d   = high_q;
      period_d = period_q;
      hout_d   = hout_q;
      valid_d  = 1'b0;
      ovf_set  = 1'b0;
      if (!i_en) begin
         state_d = S_IDLE;
         per_d   = '0;
         high_d  = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               per_d  = '0;
               high_d = '0;
               if (rise_q) begin
                  state_d = S_HIGH;
                  per_d   = CNT_ONE;
                  high_d  = CNT_ONE;
               end
            end
            S_HIGH: begin
               if (per_q == CNT_MAX) begin
                  ovf_set = 1'b1;
                  state_d = S_IDLE;
                  per_d   = '0;
                  high_d  = '0;
               end else begin
                  per_d = per_q + CNT_ONE;
                  if (fall_q) state_d = S_LOW;
                  else        high_d  = high_q + CNT_ONE;
               end
            end
            S_LOW: begin
               // A closing rise is captured even when the period count is all-ones.
               if (rise_q) begin
                  period_d = per_q;
                  hout_d   = high_q;
                  valid_d  = 1'b1;
                  state_d  = S_HIGH;
                  per_d    = CNT_ONE;
                  high_d   = CNT_ONE;
               end else if (per_q == CNT_MAX) begin
                  ovf_set = 1'b1;
                  state_d = S_IDLE;
                  per_d   = '0;
                  high_d  = '0;
               end else begin
                  per_d = per_q + CNT_ONE;
               end
            end
            default: begin
               state_d = S_IDLE;
               per_d   = '0;
               high_d  = '0;
            end
         endcase
      end
      ovf_d = ovf_set | (ovf_q & ~i_clear);
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         sync_q   <= 2'b00;
         level_q  <= 1'b0;
         run_q    <= 4'd0;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
         state_q  <= S_IDLE;
         per_q    <= '0;
         high_q   <= '0;
         period_q <= '0;
         hout_q   <= '0;
         valid_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         sync_q   <= {sync_q[0], i_pwm};
         level_q  <= level_d;
         run_q    <= run_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
         state_q  <= state_d;
         per_q    <= per_d;
         high_q   <= high_d;
         period_q <= period_d;
         hout_q   <= hout_d;
         valid_q  <= valid_d;
         ovf_q    <= ovf_d;
      end
   end

   assign o_period   = period_q;
   assign o_high     = hout_q;
   assign o_valid    = valid_q;
   assign o_overflow = ovf_q;
   assign o_level    = level_q;

endmodule

// File: tb/tb_project_pwm_capture.sv
// Scoreboarded bench: the PWM driver predicts each (period, high) pair from the
// waveform segment lengths; a monitor pops and compares on every o_valid.
module tb_project_pwm_capture;

   localparam int W    = 12;
   localparam int MAXV = (1 << W) - 1;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         en;
   logic         pwm;
   logic [3:0]   filt;
   logic         clr;
   logic [W-1:0] period, high;
   logic         valid, ovf, level;

   project_pwm_capture #(.P_WIDTH(W)) dut (
      .i_clk      (clk),
      .i_reset    (rst_n),
      .i_en       (en),
      .i_pwm      (pwm),
      .i_filter   (filt),
      .i_clear    (clr),
      .o_period   (period),
      .o_high     (high),
      .o_valid    (valid),
      .o_overflow (ovf),
      .o_level    (level)
   );

   always #5 clk = ~clk;

   typedef struct {int per; int hi;} exp_t;
   exp_t exp_q[$];

   int vectors = 0;
   int miscompares = 0;

   // Reference model: measurement in progress, current waveform level, accumulated lengths.
   bit m_meas = 0;
   bit m_level = 0;
   int m_per = 0, m_high = 0, m_last_per = 0, m_last_high = 0;

   bit cnt_en = 0;
   int ovf_cnt = 0;

   task automatic chk(input string name, input int act, input int req);
      vectors++;
      if (act != req) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && valid) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_valid: got period %0d high %0d, expected no o_valid",
                     period, high);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("o_period", int'(period), e.per);
            chk("o_high", int'(high), e.hi);
         end
      end
   end

   always @(negedge clk) begin
      if (!cnt_en)  ovf_cnt = 0;
      else if (ovf) ovf_cnt++;
   end

   task automatic model_seg(input bit lvl, input int n);
      exp_t e;
      if (lvl && !m_level) begin
         if (m_meas) begin
            e.per = m_per;
            e.hi  = m_high;
            exp_q.push_back(e);
            m_last_per  = m_per;
            m_last_high = m_high;
         end
         m_meas = 1;
         m_per  = 0;
         m_high = 0;
      end
      m_level = lvl;
      if (m_meas) begin
         m_per += n;
         if (lvl) m_high += n;
         if (m_per > MAXV) m_meas = 0;
      end
   endtask

   // Called at a negedge; returns at the negedge n cycles later.
   task automatic drive_raw(input bit lvl, input int n);
      pwm = lvl;
      repeat (n) @(negedge clk);
   endtask

   task automatic drive_seg(input bit lvl, input int n);
      model_seg(lvl, n);
      drive_raw(lvl, n);
   endtask

   // Filter changes alter the edge latency, so restart the measurement around them.
   task automatic set_filter(input int f);
      drive_seg(1'b0, 20);
      en = 1'b0;
      m_meas = 0;
      filt = 4'(f);
      @(negedge clk);
      en = 1'b1;
      drive_seg(1'b0, 20);
   endtask

   initial begin
      int lat;
      rst_n = 1'b0; en = 1'b1; pwm = 1'b0; filt = 4'd0; clr = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_period", int'(period), 0);
      chk("reset_high", int'(high), 0);
      chk("reset_valid", int'(valid), 0);
      chk("reset_overflow", int'(ovf), 0);
      chk("reset_level", int'(level), 0);
      rst_n = 1'b1;
      drive_seg(1'b0, 10);

      // 60-cycle period, 29 high
      repeat (5) begin
         drive_seg(1'b1, 29);
         drive_seg(1'b0, 31);
      end
      chk("level_low_settled", int'(level), 0);

      // 2-cycle period
      repeat (12) begin
         drive_seg(1'b1, 1);
         drive_seg(1'b0, 1);
      end
      drive_seg(1'b0, 20);

      // Glitch with filter 0: the glitch shows up as real edges
      repeat (3) begin
         drive_seg(1'b1, 10);
         drive_seg(1'b0, 2);
         drive_seg(1'b1, 17);
         drive_seg(1'b0, 31);
      end

      // Glitch with filter 3: swallowed; also measure input-to-level latency
      set_filter(3);
      model_seg(1'b1, 29);
      pwm = 1'b1;
      lat = 0;
      for (int k = 1; k <= 29; k++) begin
         @(posedge clk);
         #1;
         if (level && lat == 0) lat = k;
      end
      @(negedge clk);
      chk("level_latency_f3", lat, 6);
      drive_seg(1'b0, 31);
      repeat (3) begin
         model_seg(1'b1, 29);
         drive_raw(1'b1, 10);
         drive_raw(1'b0, 2);
         drive_raw(1'b1, 17);
         drive_seg(1'b0, 31);
      end
      drive_seg(1'b1, 29);
      drive_seg(1'b0, 31);

      // Enable dropped for 5 cycles inside a low phase
      set_filter(0);
      drive_seg(1'b1, 29);
      drive_seg(1'b0, 31);
      drive_seg(1'b1, 29);
      drive_seg(1'b0, 10);
      en = 1'b0;
      m_meas = 0;
      repeat (5) @(negedge clk);
      en = 1'b1;
      drive_seg(1'b0, 16);
      repeat (3) begin
         drive_seg(1'b1, 29);
         drive_seg(1'b0, 31);
      end

      // Overflow: long high, then clear
      drive_seg(1'b1, MAXV + 200);
      drive_seg(1'b0, 20);
      chk("overflow_set", int'(ovf), 1);
      chk("overflow_period_kept", int'(period), m_last_per);
      chk("overflow_high_kept", int'(high), m_last_high);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("overflow_cleared", int'(ovf), 0);

      // Clear held while overflow sets: set wins for exactly one cycle
      cnt_en = 1'b1;
      clr = 1'b1;
      drive_seg(1'b1, 29);
      drive_seg(1'b0, 31);
      drive_seg(1'b1, MAXV + 200);
      drive_seg(1'b0, 20);
      clr = 1'b0;
      cnt_en = 1'b0;
      chk("overflow_pulse_under_clear", ovf_cnt, 1);
      chk("overflow_after_clear", int'(ovf), 0);
      repeat (3) begin
         drive_seg(1'b1, 29);
         drive_seg(1'b0, 31);
      end

      // Reset asserted mid-high, released in a low phase
      drive_seg(1'b1, 29);
      drive_seg(1'b0, 31);
      model_seg(1'b1, 15);
      drive_raw(1'b1, 15);
      #2 rst_n = 1'b0;
      #1;
      chk("midreset_period", int'(period), 0);
      chk("midreset_high", int'(high), 0);
      chk("midreset_valid", int'(valid), 0);
      chk("midreset_overflow", int'(ovf), 0);
      chk("midreset_level", int'(level), 0);
      pwm = 1'b0;
      m_meas = 0; m_level = 0; m_last_per = 0; m_last_high = 0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      drive_seg(1'b0, 20);
      repeat (4) begin
         drive_seg(1'b1, 29);
         drive_seg(1'b0, 31);
      end

      // Randomized trains across random filter settings
      for (int r = 0; r < 5; r++) begin
         int f;
         f = int'($urandom_range(15, 0));
         set_filter(f);
         for (int p = 0; p < 12; p++) begin
            drive_seg(1'b1, int'($urandom_range(f + 30, f + 1)));
            drive_seg(1'b0, int'($urandom_range(f + 30, f + 1)));
         end
      end

      drive_seg(1'b0, 40);
      chk("pending_expectations", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
